// File: rtl/wormhole_out_arbiter_pkg.sv
// Shared flit encoding, field widths and FSM state type for the wormhole
// output-port arbiter.
package wormhole_out_arbiter_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned TYPE_W = 3;
   localparam int unsigned LEN_W  = 12;

   localparam logic [TYPE_W-1:0] HEADER  = 3'd1;
   localparam logic [TYPE_W-1:0] PAYLOAD = 3'd2;
   localparam logic [TYPE_W-1:0] TAIL    = 3'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// scanning upward with wrap-around.
module rr_arbiter #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned PTR_W = $clog2(N_IN)
) (
   input  logic [N_IN-1:0]  req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_IN-1:0]  gnt_o,
   output logic [PTR_W-1:0] idx_o,
   output logic             valid_o
);

   logic             found;
   logic [PTR_W-1:0] j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         j = PTR_W'((32'(ptr_i) + k) % N_IN);
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = j;
         end
      end
   end

   assign valid_o = found;

endmodule

// File: rtl/wormhole_out_arbiter.sv
// Packet-level round-robin owner of one downstream FIFO write port; the grant
// is held from HEADER to TAIL and packet length is checked against p_length.
module wormhole_out_arbiter
   import wormhole_out_arbiter_pkg::*;
#(
   parameter int unsigned N_IN       = 4,
   parameter int unsigned DATA_WIDTH = DATA_W,
   parameter int unsigned PTR_W      = $clog2(N_IN)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_IN-1:0]            in_empty,
   input  logic [N_IN*DATA_WIDTH-1:0] in_data,
   output logic [N_IN-1:0]            rd_en,
   input  logic                       out_ready,
   output logic                       wr_en,
   output logic [DATA_WIDTH-1:0]      data_out,
   output logic [N_IN-1:0]            grant,
   output logic                       pkt_err
);

   localparam int unsigned TYPE_MSB = DATA_WIDTH - 1;
   localparam int unsigned LEN_MSB  = DATA_WIDTH - 1 - TYPE_W;

   arb_state_e                            state_q, state_d;
   logic [PTR_W-1:0]                      rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]                      gidx_q, gidx_d;
   logic [N_IN-1:0]                       grant_q, grant_d;
   logic [LEN_W-1:0]                      rem_q, rem_d;
   logic                                  first_q, first_d;

   logic [N_IN-1:0][DATA_WIDTH-1:0]       heads;
   logic [N_IN-1:0]                       cand_gnt;
   logic [PTR_W-1:0]                      cand_idx;
   logic                                  cand_valid;
   logic [TYPE_W-1:0]                     cand_type;
   logic [DATA_WIDTH-1:0]                 cur_flit;
   logic [TYPE_W-1:0]                     cur_type;
   logic [LEN_W-1:0]                      cur_len;
   logic [LEN_W-1:0]                      len_eff;
   logic                                  done;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(N_IN - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign heads     = in_data;
   assign cand_type = heads[cand_idx][TYPE_MSB -: TYPE_W];
   assign cur_flit  = heads[gidx_q];
   assign cur_type  = cur_flit[TYPE_MSB -: TYPE_W];
   assign cur_len   = cur_flit[LEN_MSB -: LEN_W];
   assign grant     = grant_q;

   rr_arbiter #(
      .N_IN  (N_IN),
      .PTR_W (PTR_W)
   ) u_rr (
      .req_i   (~in_empty),
      .ptr_i   (rr_ptr_q),
      .gnt_o   (cand_gnt),
      .idx_o   (cand_idx),
      .valid_o (cand_valid)
   );

   // Next-state and strobes; strobes are combinational from the grant register.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gidx_d   = gidx_q;
      grant_d  = grant_q;
      rem_d    = rem_q;
      first_d  = first_q;
      rd_en    = '0;
      wr_en    = 1'b0;
      data_out = '0;
      pkt_err  = 1'b0;
      len_eff  = '0;
      done     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (cand_valid) begin
               if (cand_type == HEADER) begin
                  grant_d = cand_gnt;
                  gidx_d  = cand_idx;
                  first_d = 1'b1;
                  state_d = ST_LOCKED;
               end else begin
                  // Orphan flit with no owning header: drop it.
                  rd_en    = cand_gnt;
                  pkt_err  = 1'b1;
                  rr_ptr_d = ptr_inc(cand_idx);
               end
            end
         end
         ST_LOCKED: begin
            data_out = cur_flit;
            if (!in_empty[gidx_q] && out_ready) begin
               rd_en   = grant_q;
               wr_en   = 1'b1;
               first_d = 1'b0;
               if (cur_type == HEADER) begin
                  len_eff = (cur_len == '0) ? LEN_W'(1) : cur_len;
                  rem_d   = len_eff - LEN_W'(1);
                  pkt_err = (cur_len == '0) || !first_q;
                  done    = first_q && (len_eff == LEN_W'(1));
               end else if (cur_type == TAIL) begin
                  pkt_err = (rem_q != LEN_W'(1));
                  done    = 1'b1;
               end else begin
                  pkt_err = (rem_q <= LEN_W'(1)) || (cur_type != PAYLOAD);
                  rem_d   = (rem_q == '0) ? '0 : rem_q - LEN_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (done) begin
         state_d  = ST_IDLE;
         grant_d  = '0;
         rem_d    = '0;
         rr_ptr_d = ptr_inc(gidx_q);
      end

      // Nothing moves while reset is asserted, even mid-packet.
      if (rst) begin
         rd_en    = '0;
         wr_en    = 1'b0;
         data_out = '0;
         pkt_err  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         gidx_q   <= '0;
         grant_q  <= '0;
         rem_q    <= '0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gidx_q   <= gidx_d;
         grant_q  <= grant_d;
         rem_q    <= rem_d;
         first_q  <= first_d;
      end
   end

endmodule

// File: tb/tb_wormhole_out_arbiter.sv
// Directed vector table plus a FIFO-model contention sequence for
// wormhole_out_arbiter.
module tb_wormhole_out_arbiter;
   import wormhole_out_arbiter_pkg::*;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [3:0]   in_empty = 4'hF;
   logic [127:0] in_data = '0;
   logic [3:0]   rd_en;
   logic         out_ready = 1'b1;
   logic         wr_en;
   logic [31:0]  data_out;
   logic [3:0]   grant;
   logic         pkt_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wormhole_out_arbiter #(.N_IN(4), .DATA_WIDTH(32), .PTR_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_empty  (in_empty),
      .in_data   (in_data),
      .rd_en     (rd_en),
      .out_ready (out_ready),
      .wr_en     (wr_en),
      .data_out  (data_out),
      .grant     (grant),
      .pkt_err   (pkt_err)
   );

   typedef struct packed {
      logic             rst;
      logic             rdy;
      logic [3:0]       emp;
      logic [3:0][31:0] heads;
      logic [3:0]       e_rd;
      logic             e_wr;
      logic [31:0]      e_data;
      logic [3:0]       e_gnt;
      logic             e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] fl(input logic [2:0] t, input int unsigned len,
                                      input int unsigned tag);
      return {t, 12'(len), 17'(tag)};
   endfunction

   function automatic logic [3:0][31:0] at(input logic [1:0] i, input logic [31:0] f);
      logic [3:0][31:0] r;
      r    = '0;
      r[i] = f;
      return r;
   endfunction

   task automatic add(input logic r, input logic rdy, input logic [3:0] emp,
                      input logic [3:0][31:0] h, input logic [3:0] erd, input logic ewr,
                      input logic [31:0] ed, input logic [3:0] eg, input logic ee);
      vecs.push_back('{r, rdy, emp, h, erd, ewr, ed, eg, ee});
   endtask

   // Idle-looking cycle: no strobes and no owner expected.
   task automatic z(input logic [3:0] emp, input logic [3:0][31:0] h);
      add(1'b0, 1'b1, emp, h, 4'b0000, 1'b0, 32'h0, 4'b0000, 1'b0);
   endtask

   // Transfer of flit f from sole requester i while it owns the output.
   task automatic x(input logic [1:0] i, input logic [31:0] f, input logic err);
      logic [3:0] oh;
      oh = 4'b0001 << i;
      add(1'b0, 1'b1, ~oh, at(i, f), oh, 1'b1, f, oh, err);
   endtask

   logic [31:0] a_h, a_p, a_t, b_h, b_p, b_t, c_h, c_p, c_t, d_h1, e_h0;
   logic [31:0] o_p, o_h, o_t, l_h3, l_h2, l_t, v_h2, v_p, v_t, u_h3, u_x, u_t;
   logic [31:0] r_h4, r_p, s0_h, s0_t, s1_h, s1_t;
   logic [31:0] fq[4][$];
   logic [31:0] exp_q[$];

   initial begin
      a_h  = fl(HEADER, 3, 'h20);  a_p = fl(PAYLOAD, 0, 'h21); a_t = fl(TAIL, 0, 'h22);
      b_h  = fl(HEADER, 3, 'h10);  b_p = fl(PAYLOAD, 0, 'h11); b_t = fl(TAIL, 0, 'h12);
      c_h  = fl(HEADER, 4, 'h30);  c_p = fl(PAYLOAD, 0, 'h31); c_t = fl(TAIL, 0, 'h32);
      d_h1 = fl(HEADER, 1, 'h40);  e_h0 = fl(HEADER, 0, 'h41);
      o_p  = fl(PAYLOAD, 0, 'h50); o_h = fl(HEADER, 2, 'h51);  o_t = fl(TAIL, 0, 'h52);
      l_h3 = fl(HEADER, 3, 'h60);  l_h2 = fl(HEADER, 2, 'h61); l_t = fl(TAIL, 0, 'h62);
      v_h2 = fl(HEADER, 2, 'h70);  v_p = fl(PAYLOAD, 0, 'h71); v_t = fl(TAIL, 0, 'h72);
      u_h3 = fl(HEADER, 3, 'h80);  u_x = fl(3'd7, 0, 'h81);    u_t = fl(TAIL, 0, 'h82);
      r_h4 = fl(HEADER, 4, 'h90);  r_p = fl(PAYLOAD, 0, 'h91);
      s0_h = fl(HEADER, 2, 'hA0);  s0_t = fl(TAIL, 0, 'hA2);
      s1_h = fl(HEADER, 2, 'hA1);  s1_t = fl(TAIL, 0, 'hA3);

      // Reset state, then single len=3 packet on input 2.
      z(4'b1111, '0);
      z(4'b1011, at(2'd2, a_h));
      x(2'd2, a_h, 1'b0);
      x(2'd2, a_p, 1'b0);
      x(2'd2, a_t, 1'b0);
      z(4'b1111, '0);
      // Backpressure on input 1: three not-ready cycles and one empty cycle.
      z(4'b1101, at(2'd1, b_h));
      x(2'd1, b_h, 1'b0);
      add(1'b0, 1'b0, 4'b1101, at(2'd1, b_p), 4'b0000, 1'b0, b_p, 4'b0010, 1'b0);
      add(1'b0, 1'b0, 4'b1101, at(2'd1, b_p), 4'b0000, 1'b0, b_p, 4'b0010, 1'b0);
      add(1'b0, 1'b0, 4'b1101, at(2'd1, b_p), 4'b0000, 1'b0, b_p, 4'b0010, 1'b0);
      x(2'd1, b_p, 1'b0);
      add(1'b0, 1'b1, 4'b1111, '0, 4'b0000, 1'b0, 32'h0, 4'b0010, 1'b0);
      x(2'd1, b_t, 1'b0);
      z(4'b1111, '0);
      // Short packet: len=4 ended after three flits.
      z(4'b1110, at(2'd0, c_h));
      x(2'd0, c_h, 1'b0);
      x(2'd0, c_p, 1'b0);
      x(2'd0, c_t, 1'b1);
      // Single-flit packets, len=1 clean and len=0 flagged.
      z(4'b1110, at(2'd0, d_h1));
      x(2'd0, d_h1, 1'b0);
      z(4'b1111, '0);
      z(4'b1110, at(2'd0, e_h0));
      x(2'd0, e_h0, 1'b1);
      z(4'b1111, '0);
      // Orphan payload at input 3, then a proper packet from input 3.
      add(1'b0, 1'b1, 4'b0111, at(2'd3, o_p), 4'b1000, 1'b0, 32'h0, 4'b0000, 1'b1);
      z(4'b0111, at(2'd3, o_h));
      x(2'd3, o_h, 1'b0);
      x(2'd3, o_t, 1'b0);
      z(4'b1111, '0);
      // Header while locked reloads the count and keeps the lock.
      z(4'b1110, at(2'd0, l_h3));
      x(2'd0, l_h3, 1'b0);
      x(2'd0, l_h2, 1'b1);
      x(2'd0, l_t, 1'b0);
      z(4'b1111, '0);
      // Payload overrun, then tail with count already zero.
      z(4'b1110, at(2'd0, v_h2));
      x(2'd0, v_h2, 1'b0);
      x(2'd0, v_p, 1'b1);
      x(2'd0, v_t, 1'b1);
      z(4'b1111, '0);
      // Unused type code behaves as payload but is flagged.
      z(4'b1110, at(2'd0, u_h3));
      x(2'd0, u_h3, 1'b0);
      x(2'd0, u_x, 1'b1);
      x(2'd0, u_t, 1'b0);
      z(4'b1111, '0);
      // Reset on the second flit; afterwards pointer must be back at 0.
      z(4'b1110, at(2'd0, r_h4));
      x(2'd0, r_h4, 1'b0);
      add(1'b1, 1'b1, 4'b1110, at(2'd0, r_p), 4'b0000, 1'b0, 32'h0, 4'b0001, 1'b0);
      z(4'b1100, at(2'd0, s0_h) | at(2'd1, s1_h));
      add(1'b0, 1'b1, 4'b1100, at(2'd0, s0_h) | at(2'd1, s1_h),
          4'b0001, 1'b1, s0_h, 4'b0001, 1'b0);
      add(1'b0, 1'b1, 4'b1100, at(2'd0, s0_t) | at(2'd1, s1_h),
          4'b0001, 1'b1, s0_t, 4'b0001, 1'b0);
      z(4'b1101, at(2'd1, s1_h));
      x(2'd1, s1_h, 1'b0);
      x(2'd1, s1_t, 1'b0);
      z(4'b1111, '0);

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         rst       = vecs[k].rst;
         out_ready = vecs[k].rdy;
         in_empty  = vecs[k].emp;
         in_data   = vecs[k].heads;
         #1;
         checks++;
         if ({rd_en, wr_en, data_out, grant, pkt_err} !==
             {vecs[k].e_rd, vecs[k].e_wr, vecs[k].e_data, vecs[k].e_gnt, vecs[k].e_err}) begin
            failures++;
            $display("FAIL vec%0d: got rd=%b wr=%b data=%h gnt=%b err=%b, want rd=%b wr=%b data=%h gnt=%b err=%b",
                     k, rd_en, wr_en, data_out, grant, pkt_err, vecs[k].e_rd, vecs[k].e_wr,
                     vecs[k].e_data, vecs[k].e_gnt, vecs[k].e_err);
         end
      end

      // Contention: two len=2 packets on each of inputs 0 and 1.
      fq[0] = '{fl(HEADER, 2, 'h100), fl(TAIL, 0, 'h101), fl(HEADER, 2, 'h102), fl(TAIL, 0, 'h103)};
      fq[1] = '{fl(HEADER, 2, 'h110), fl(TAIL, 0, 'h111), fl(HEADER, 2, 'h112), fl(TAIL, 0, 'h113)};
      exp_q = '{fl(HEADER, 2, 'h100), fl(TAIL, 0, 'h101), fl(HEADER, 2, 'h110), fl(TAIL, 0, 'h111),
                fl(HEADER, 2, 'h102), fl(TAIL, 0, 'h103), fl(HEADER, 2, 'h112), fl(TAIL, 0, 'h113)};
      begin
         int got = 0;
         int errs = 0;
         logic [3:0] rd_s;
         logic [3:0][31:0] hd;
         for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            rst       = 1'b0;
            out_ready = 1'b1;
            hd        = '0;
            for (int i = 0; i < 4; i++) begin
               in_empty[2'(i)] = (fq[i].size() == 0);
               if (fq[i].size() != 0) hd[2'(i)] = fq[i][0];
            end
            in_data = hd;
            #1;
            rd_s = rd_en;
            if (pkt_err) errs++;
            if (wr_en) begin
               checks++;
               if (got >= 8 || data_out !== exp_q[got]) begin
                  failures++;
                  $display("FAIL cont_flit%0d: got %h, want %h", got, data_out,
                           (got < 8) ? exp_q[got] : 32'h0);
               end
               got++;
            end
            @(posedge clk);
            for (int i = 0; i < 4; i++)
               if (rd_s[2'(i)] && fq[i].size() != 0) void'(fq[i].pop_front());
         end
         checks++;
         if (got != 8) begin
            failures++;
            $display("FAIL cont_count: got %0d flits, want 8", got);
         end
         checks++;
         if (errs != 0) begin
            failures++;
            $display("FAIL cont_err: got %0d pkt_err pulses, want 0", errs);
         end
      end

      @(negedge clk);
      in_empty = 4'hF;
      in_data  = '0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wormhole_out_arbiter.md
Name: wormhole_out_arbiter

Overview:
- Output-port allocator for the NoC router. It shares one downstream FIFO write port among N_IN input FIFOs (`fifo_onehot` instances).
- Grants are round-robin at packet level, wormhole style: a grant is locked from the HEADER flit through the TAIL flit.
- It drives rd_en to the input FIFOs and wr_en/data to the downstream FIFO, with flow control from that FIFO's ready_out.
- It checks packet length against the header p_length field and flags malformed traffic.

Parameters:
- N_IN, 4, number of input FIFOs competing for the output.
- DATA_WIDTH, `DATA_WIDTH (32), flit width.
- PTR_W, $clog2(N_IN), width of the round-robin pointer and grant index.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_empty  in  N_IN  empty flag of each input FIFO.
- in_data  in  N_IN*DATA_WIDTH  head flit of each input FIFO; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]. The FIFO presents the head flit while not empty (first-word-fall-through).
- rd_en  out  N_IN  pop strobe to each input FIFO; at most one bit is set.
- out_ready  in  1  ready_out of the downstream FIFO.
- wr_en  out  1  write strobe to the downstream FIFO.
- data_out  out  DATA_WIDTH  flit to the downstream FIFO.
- grant  out  N_IN  one-hot current owner; all zero when idle.
- pkt_err  out  1  one-cycle pulse on any protocol error.

Behaviour:
- Flit fields:
  - type = flit[DATA_WIDTH-1 -: 3] (HEADER / PAYLOAD / TAIL codes).
  - p_length = flit[DATA_WIDTH-4 -: 12].
  - Parity bit 0 is passed through unchecked.
- Reset values:
  - state=IDLE, rr_ptr=0, grant=0, remaining=0.
  - rd_en=0, wr_en=0, data_out=0, pkt_err=0.
  - A reset asserted mid-packet drops the lock immediately; no flit is popped or written in the reset cycle.
- FSM states are IDLE and LOCKED.
- IDLE behaviour:
  - Candidate = first non-empty input scanning rr_ptr, rr_ptr+1, … modulo N_IN.
  - If the candidate's head is HEADER: register grant=candidate and go to LOCKED. No transfer happens in this cycle, so arbitration latency is 1 cycle.
  - If the candidate's head is not HEADER (orphan flit): assert rd_en[candidate] for one cycle, keep wr_en=0, pulse pkt_err, set rr_ptr=candidate+1, and stay in IDLE.
  - If no input is non-empty: outputs stay idle.
- LOCKED transfer:
  - A transfer occurs when ~in_empty[g] & out_ready; then rd_en[g]=1 and wr_en=1 in the same cycle.
  - wr_en, rd_en and data_out are combinational from the grant register, the selected in_data and the flags.
  - data_out = in_data of g while LOCKED, otherwise 0.
  - Stall: no strobes while in_empty[g] or ~out_ready. The grant is held and the state does not change.
- HEADER transfer:
  - Load remaining = p_length - 1.
  - If p_length==0, pulse pkt_err and treat the packet as length 1.
  - If the effective length is 1, this is a single-flit packet: release as for TAIL.
- PAYLOAD transfer:
  - remaining -= 1.
  - If remaining was already 1 or 0, pulse pkt_err; remaining saturates at 0.
- TAIL transfer:
  - If remaining != 1, pulse pkt_err.
  - Release: grant=0, rr_ptr=g+1 (wraps to 0 at N_IN-1), go to IDLE.
- HEADER arriving while LOCKED: forward it, pulse pkt_err, reload remaining from its p_length, and keep the lock.
- Minimum packet period is 1 arbitration cycle plus p_length transfer cycles. A back-to-back request from the same input waits behind every other requesting input.
- Fairness: the last owner has the lowest priority in the next arbitration. An input that requests continuously waits at most N_IN-1 packets.
- Unused type codes count as PAYLOAD and also pulse pkt_err.

Decomposition:
- Flit codes (`HEADER`, `PAYLOAD`, `TAIL`), `DATA_WIDTH` and the field offsets live in the shared include parameters.v.
- Sub-module rr_arbiter (N_IN request vector plus PTR_W pointer → one-hot grant and index). It is purely combinational and reused later by the crossbar allocator.
- The FSM, length counter and datapath mux stay in wormhole_out_arbiter.

Test Plan:
- Single packet: input 2 holds H(len=3), P, T; out_ready=1.
  - grant=4'b0100 one cycle after the header appears.
  - wr_en is high for 3 consecutive cycles with data in order, then grant=0.
  - pkt_err is never set.
- Contention: inputs 0 and 1 each hold two len=2 packets.
  - Output packet order is 0, 1, 0, 1.
  - Flits never interleave within a packet.
- Backpressure: out_ready is deasserted for 3 cycles mid-packet.
  - wr_en and rd_en stay 0 and the grant is held.
  - The transfer resumes with the next flit and there is no duplication.
- Length errors:
  - H(len=4), P, T → pkt_err on the TAIL cycle, lock released.
  - H(len=1) alone → released after the header with no error.
- Orphan flit: PAYLOAD at the head of input 3 while IDLE.
  - rd_en[3] pulses once with wr_en=0 and pkt_err=1.
  - A subsequent HEADER from input 3 is granted.
- Reset mid-packet: rst during the second flit of a len=4 packet.
  - Next cycle: grant=0, state IDLE, rr_ptr=0, no strobes during the reset cycle.
